// File: rtl/deassert_monitor.sv
// Multi-channel assertion/deassertion checker: per-channel fall, timeout and glitch
// detection with sticky error flags and a saturating deassertion-event counter.
module deassert_monitor #(
    parameter int unsigned   N           = 4,
    parameter int unsigned   MAX_HIGH    = 4,
    parameter int unsigned   MIN_LOW     = 2,
    parameter int unsigned   CNT_W       = 8,
    parameter logic [N-1:0]  ACTIVE_HIGH = {N{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     sig_in,
    input  logic [N-1:0]     clr_err,
    output logic [N-1:0]     fall_pulse,
    output logic [N-1:0]     timeout_pulse,
    output logic [N-1:0]     glitch_pulse,
    output logic [N-1:0]     err_sticky,
    output logic             any_err,
    output logic [CNT_W-1:0] fall_count
);

    localparam int unsigned HW = $clog2(MAX_HIGH + 1);
    localparam int unsigned LW = $clog2(MIN_LOW + 1);
    localparam int unsigned SW = CNT_W + $clog2(N + 1);

    typedef enum logic [1:0] {S_LOW, S_HIGH, S_STUCK} state_e;

    state_e          r_state      [N];
    state_e          w_state_d    [N];
    logic [HW-1:0]   r_high_cnt   [N];
    logic [HW-1:0]   w_high_cnt_d [N];
    logic [LW-1:0]   r_low_cnt    [N];
    logic [LW-1:0]   w_low_cnt_d  [N];

    logic [N-1:0]     w_act;
    logic [N-1:0]     w_fall_d;
    logic [N-1:0]     w_timeout_d;
    logic [N-1:0]     w_glitch_d;
    logic [N-1:0]     w_err_d;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] w_count_d;

    logic [N-1:0]     r_fall;
    logic [N-1:0]     r_timeout;
    logic [N-1:0]     r_glitch;
    logic [N-1:0]     r_err;
    logic             r_any;
    logic [CNT_W-1:0] r_count;

    assign w_act = sig_in ~^ ACTIVE_HIGH;

    always_comb begin
        w_fall_d    = '0;
        w_timeout_d = '0;
        w_glitch_d  = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_state_d[i]    = r_state[i];
            w_high_cnt_d[i] = r_high_cnt[i];
            w_low_cnt_d[i]  = r_low_cnt[i];
            case (r_state[i])
                S_LOW: begin
                    if (w_act[i]) begin
                        w_state_d[i]    = S_HIGH;
                        w_high_cnt_d[i] = HW'(1);
                        w_glitch_d[i]   = (r_low_cnt[i] < LW'(MIN_LOW));
                    end else if (r_low_cnt[i] < LW'(MIN_LOW)) begin
                        w_low_cnt_d[i] = r_low_cnt[i] + LW'(1);
                    end
                end
                S_HIGH: begin
                    if (!w_act[i]) begin
                        w_state_d[i]   = S_LOW;
                        w_low_cnt_d[i] = LW'(1);
                        w_fall_d[i]    = 1'b1;
                    end else if (r_high_cnt[i] < HW'(MAX_HIGH)) begin
                        w_high_cnt_d[i] = r_high_cnt[i] + HW'(1);
                    end else begin
                        w_state_d[i]   = S_STUCK;
                        w_timeout_d[i] = 1'b1;
                    end
                end
                S_STUCK: begin
                    // Stay here silently until the fall; one timeout per episode.
                    if (!w_act[i]) begin
                        w_state_d[i]   = S_LOW;
                        w_low_cnt_d[i] = LW'(1);
                        w_fall_d[i]    = 1'b1;
                    end
                end
                default: w_state_d[i] = S_LOW;
            endcase
        end
    end

    always_comb begin
        // Set dominates clear when both land on the same edge.
        w_err_d = w_timeout_d | w_glitch_d | (r_err & ~clr_err);
        w_sum   = {{(SW - CNT_W){1'b0}}, r_count};
        for (int i = 0; i < int'(N); i++) begin
            w_sum = w_sum + SW'(w_fall_d[i]);
        end
        if (w_sum > {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
            w_count_d = '1;
        end else begin
            w_count_d = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N); i++) begin
                r_state[i]    <= S_LOW;
                r_high_cnt[i] <= '0;
                // Start saturated so the first rise after reset is not a glitch.
                r_low_cnt[i]  <= LW'(MIN_LOW);
            end
            r_fall    <= '0;
            r_timeout <= '0;
            r_glitch  <= '0;
            r_err     <= '0;
            r_any     <= 1'b0;
            r_count   <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                r_state[i]    <= w_state_d[i];
                r_high_cnt[i] <= w_high_cnt_d[i];
                r_low_cnt[i]  <= w_low_cnt_d[i];
            end
            r_fall    <= w_fall_d;
            r_timeout <= w_timeout_d;
            r_glitch  <= w_glitch_d;
            r_err     <= w_err_d;
            r_any     <= |w_err_d;
            r_count   <= w_count_d;
        end
    end

    assign fall_pulse    = r_fall;
    assign timeout_pulse = r_timeout;
    assign glitch_pulse  = r_glitch;
    assign err_sticky    = r_err;
    assign any_err       = r_any;
    assign fall_count    = r_count;

endmodule

// File: tb/tb_deassert_monitor.sv
// Directed bench for deassert_monitor: run-length reference model checked every cycle
// on two instances (all active-high, and ch0 active-low), plus literal spot checks.
module tb_deassert_monitor;

    localparam int          MAX_HIGH = 4;
    localparam int          MIN_LOW  = 2;
    localparam logic [3:0]  POL0     = 4'b1111;
    localparam logic [3:0]  POL1     = 4'b1110;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sig     = 4'b0000;
    logic [3:0] sig_b   = 4'b0001;
    logic [3:0] clr_err = 4'b0000;

    logic [3:0] fall_pulse, timeout_pulse, glitch_pulse, err_sticky;
    logic       any_err;
    logic [7:0] fall_count;
    logic [3:0] fall_pulse_b, timeout_pulse_b, glitch_pulse_b, err_sticky_b;
    logic       any_err_b;
    logic [7:0] fall_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    deassert_monitor #(
        .N(4), .MAX_HIGH(MAX_HIGH), .MIN_LOW(MIN_LOW), .CNT_W(8), .ACTIVE_HIGH(POL0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sig_in(sig), .clr_err(clr_err),
        .fall_pulse(fall_pulse), .timeout_pulse(timeout_pulse),
        .glitch_pulse(glitch_pulse), .err_sticky(err_sticky),
        .any_err(any_err), .fall_count(fall_count)
    );

    deassert_monitor #(
        .N(4), .MAX_HIGH(MAX_HIGH), .MIN_LOW(MIN_LOW), .CNT_W(8), .ACTIVE_HIGH(POL1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_b), .clr_err(clr_err),
        .fall_pulse(fall_pulse_b), .timeout_pulse(timeout_pulse_b),
        .glitch_pulse(glitch_pulse_b), .err_sticky(err_sticky_b),
        .any_err(any_err_b), .fall_count(fall_count_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: length of the current asserted run and of the current low run.
    int         hi_run [2][4];
    int         lo_run [2][4];
    int         m_fcnt [2];
    logic [3:0] m_fall [2];
    logic [3:0] m_to   [2];
    logic [3:0] m_gl   [2];
    logic [3:0] m_err  [2];
    logic       m_any  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                hi_run[k][i] = 0;
                lo_run[k][i] = MIN_LOW;
            end
            m_fcnt[k] = 0;
            m_fall[k] = '0;
            m_to[k]   = '0;
            m_gl[k]   = '0;
            m_err[k]  = '0;
            m_any[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] s;
            logic [3:0] pol;
            int         nf;
            s   = (k == 0) ? sig : sig_b;
            pol = (k == 0) ? POL0 : POL1;
            nf  = 0;
            m_fall[k] = '0;
            m_to[k]   = '0;
            m_gl[k]   = '0;
            for (int i = 0; i < 4; i++) begin
                if (s[i] == pol[i]) begin
                    if (hi_run[k][i] == 0 && lo_run[k][i] < MIN_LOW) m_gl[k][i] = 1'b1;
                    hi_run[k][i]++;
                    if (hi_run[k][i] == MAX_HIGH + 1) m_to[k][i] = 1'b1;
                    lo_run[k][i] = 0;
                end else begin
                    if (hi_run[k][i] > 0) begin
                        m_fall[k][i] = 1'b1;
                        nf++;
                    end
                    hi_run[k][i] = 0;
                    if (lo_run[k][i] < MIN_LOW) lo_run[k][i]++;
                end
            end
            m_err[k]  = m_to[k] | m_gl[k] | (m_err[k] & ~clr_err);
            m_any[k]  = |m_err[k];
            m_fcnt[k] = (m_fcnt[k] + nf > 255) ? 255 : m_fcnt[k] + nf;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("fall_pulse",      32'(fall_pulse),      32'(m_fall[0]));
            chk("timeout_pulse",   32'(timeout_pulse),   32'(m_to[0]));
            chk("glitch_pulse",    32'(glitch_pulse),    32'(m_gl[0]));
            chk("err_sticky",      32'(err_sticky),      32'(m_err[0]));
            chk("any_err",         32'(any_err),         32'(m_any[0]));
            chk("fall_count",      32'(fall_count),      32'(m_fcnt[0]));
            chk("fall_pulse_b",    32'(fall_pulse_b),    32'(m_fall[1]));
            chk("timeout_pulse_b", 32'(timeout_pulse_b), 32'(m_to[1]));
            chk("glitch_pulse_b",  32'(glitch_pulse_b),  32'(m_gl[1]));
            chk("err_sticky_b",    32'(err_sticky_b),    32'(m_err[1]));
            chk("any_err_b",       32'(any_err_b),       32'(m_any[1]));
            chk("fall_count_b",    32'(fall_count_b),    32'(m_fcnt[1]));
        end
    end

    // Present one sample; on return the outputs caused by that sample are visible.
    task automatic drive(input logic [3:0] s);
        sig = s;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("lit_reset_count", 32'(fall_count), 32'd0);
        chk("lit_reset_err",   32'(err_sticky), 32'd0);
        reset_n = 1'b1;

        // ch0: 3 high samples then low
        repeat (3) drive(4'b0001);
        drive(4'b0000);
        chk("lit_t1_fall",  32'(fall_pulse),    32'h1);
        chk("lit_t1_count", 32'(fall_count),    32'd1);
        chk("lit_t1_to",    32'(timeout_pulse), 32'h0);
        chk("lit_t1_err",   32'(err_sticky),    32'h0);
        drive(4'b0000);
        chk("lit_t1_fall1c", 32'(fall_pulse), 32'h0);

        // ch1: held high 6 samples
        repeat (4) drive(4'b0010);
        chk("lit_t2_to_early", 32'(timeout_pulse), 32'h0);
        drive(4'b0010);
        chk("lit_t2_to",   32'(timeout_pulse), 32'h2);
        chk("lit_t2_err",  32'(err_sticky),    32'h2);
        chk("lit_t2_any",  32'(any_err),       32'd1);
        drive(4'b0010);
        chk("lit_t2_to_once", 32'(timeout_pulse), 32'h0);
        drive(4'b0000);
        chk("lit_t2_fall",  32'(fall_pulse), 32'h2);
        chk("lit_t2_count", 32'(fall_count), 32'd2);

        // ch2: one low sample between highs, then two
        drive(4'b0100);
        drive(4'b0000);
        drive(4'b0100);
        chk("lit_t3_glitch", 32'(glitch_pulse), 32'h4);
        chk("lit_t3_err",    32'(err_sticky),   32'h6);
        drive(4'b0000);
        drive(4'b0000);
        drive(4'b0100);
        chk("lit_t3_noglitch", 32'(glitch_pulse), 32'h0);
        drive(4'b0000);
        chk("lit_t3_count", 32'(fall_count), 32'd5);

        clr_err = 4'b1111;
        drive(4'b0000);
        clr_err = 4'b0000;
        chk("lit_clr_all", 32'(err_sticky), 32'h0);
        chk("lit_clr_any", 32'(any_err),    32'd0);

        // Clear arriving on the same edge as a glitch loses to the set
        drive(4'b0100);
        drive(4'b0000);
        clr_err = 4'b0100;
        drive(4'b0100);
        chk("lit_t5_glitch", 32'(glitch_pulse), 32'h4);
        chk("lit_t5_setwin", 32'(err_sticky),   32'h4);
        drive(4'b0100);
        clr_err = 4'b0000;
        chk("lit_t5_cleared", 32'(err_sticky), 32'h0);
        chk("lit_t5_any",     32'(any_err),    32'd0);
        drive(4'b0000);
        drive(4'b0000);
        chk("lit_t5_count", 32'(fall_count), 32'd7);

        // Async reset while ch1 is stuck
        repeat (5) drive(4'b0010);
        chk("lit_t6_to", 32'(timeout_pulse), 32'h2);
        drive(4'b0010);
        #2 reset_n = 1'b0;
        #1;
        chk("lit_t6_rst_err",   32'(err_sticky), 32'h0);
        chk("lit_t6_rst_any",   32'(any_err),    32'd0);
        chk("lit_t6_rst_count", 32'(fall_count), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b0010);
        chk("lit_t6_noglitch", 32'(glitch_pulse), 32'h0);
        chk("lit_t6_nofall",   32'(fall_pulse),   32'h0);
        drive(4'b0000);
        chk("lit_t6_fall",  32'(fall_pulse), 32'h2);
        chk("lit_t6_count", 32'(fall_count), 32'd1);
        drive(4'b0000);

        // Counter saturation: bring it to 253, then fall on all four channels
        for (int r = 0; r < 63; r++) begin
            drive(4'b1111);
            drive(4'b0000);
            drive(4'b0000);
        end
        chk("lit_t4_pre", 32'(fall_count), 32'd253);
        drive(4'b1111);
        drive(4'b0000);
        chk("lit_t4_fall_all", 32'(fall_pulse), 32'hF);
        chk("lit_t4_sat",      32'(fall_count), 32'd255);
        drive(4'b0000);
        drive(4'b1111);
        drive(4'b0000);
        chk("lit_t4_hold", 32'(fall_count), 32'd255);

        // Active-low ch0 on the second instance
        sig_b = 4'b0000;
        repeat (4) drive(4'b0000);
        chk("lit_t7_to_early", 32'(timeout_pulse_b), 32'h0);
        drive(4'b0000);
        chk("lit_t7_to", 32'(timeout_pulse_b), 32'h1);
        sig_b = 4'b0001;
        drive(4'b0000);
        chk("lit_t7_fall", 32'(fall_pulse_b), 32'h1);
        drive(4'b0000);

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
